// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: requester ids, FSM states,
// default bus widths and the small helpers used by the arbiter and its picker.
package dcache_port_arbiter_pkg;

    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;
    localparam logic [Addr_Width-1:0] Addr_Mask = {{(Addr_Width-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_LD = 2'd1,
        REQ_ST = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Priority positions run ST(0), LD(1), IF(2); position p maps to id 2-p.
    function automatic logic [1:0] pos_to_id(input int pos);
        int p;
        p = pos % 3;
        return 2'(2 - p);
    endfunction

    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        if (oh[2]) return REQ_ST;
        if (oh[1]) return REQ_LD;
        return REQ_IF;
    endfunction

    // Start position of the rotation after granting requester id.
    function automatic logic [1:0] rr_next_ptr(input logic [1:0] id);
        case (id)
            REQ_ST:  return 2'd1;
            REQ_LD:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Requester and memory-bus signals of the data-memory port arbiter.
// master = arbiter side, slave = requesters plus memory.
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_done;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_wmask;
    logic              st_done;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_wdata, st_wmask,
               mem_ready, mem_rdata,
        output if_done, ld_done, st_done, resp_data, mem_req, mem_we, mem_addr,
               mem_wdata, mem_wmask, busy, timeout_err
    );

    modport slave (
        output if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_wdata, st_wmask,
               mem_ready, mem_rdata,
        input  if_done, ld_done, st_done, resp_data, mem_req, mem_we, mem_addr,
               mem_wdata, mem_wmask, busy, timeout_err
    );
endinterface

// File: rtl/dcache_port_arbiter_arb_pick3.sv
// Combinational 3-way picker: scans requests starting at priority position
// i_ptr (0 = ST, 1 = LD, 2 = IF, wrapping) and returns a one-hot grant by id.
module arb_pick3
    import dcache_port_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [2:0] o_grant
);
    logic [1:0] w_ord_id [3];
    logic [2:0] w_ord_req;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ord
        assign w_ord_id[gi]  = pos_to_id(int'(i_ptr) + gi);
        assign w_ord_req[gi] = i_req[w_ord_id[gi]];
    end

    always_comb begin
        o_grant = '0;
        if (w_ord_req[0])      o_grant[w_ord_id[0]] = 1'b1;
        else if (w_ord_req[1]) o_grant[w_ord_id[1]] = 1'b1;
        else if (w_ord_req[2]) o_grant[w_ord_id[2]] = 1'b1;
    end
endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-memory port between IF refill, LD read and ST commit,
// one transaction at a time. Define ARB_ROUND_ROBIN_EN for rotating priority.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = Addr_Width,
    parameter int DATA_W  = Data_Width,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    dcache_port_arbiter_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] W_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e        r_state;
    logic [1:0]        r_win;
    logic [CW-1:0]     r_wdog;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_resp;
    logic [3:0]        r_mem_wmask;
    logic              r_if_done, r_ld_done, r_st_done, r_busy, r_tmo;

    logic [2:0]        w_req, w_grant;
    logic [1:0]        w_win_id, w_ptr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_wmask;

    assign w_req = {bus.st_req, bus.ld_req, bus.if_req};

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd0;
`endif

    arb_pick3 u_pick (
        .i_req  (w_req),
        .i_ptr  (w_ptr),
        .o_grant(w_grant)
    );

    assign w_win_id = onehot_to_id(w_grant);

    // Reads carry no write data and enable all four lanes.
    always_comb begin
        w_addr  = bus.if_addr;
        w_wdata = '0;
        w_wmask = 4'hF;
        case (w_win_id)
            REQ_ST: begin
                w_addr  = bus.st_addr;
                w_wdata = bus.st_wdata;
                w_wmask = bus.st_wmask;
            end
            REQ_LD:  w_addr = bus.ld_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_win       <= '0;
            r_wdog      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_resp      <= '0;
            r_if_done   <= 1'b0;
            r_ld_done   <= 1'b0;
            r_st_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_tmo       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_win       <= w_win_id;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_win_id == REQ_ST);
                        r_mem_addr  <= w_addr & W_MASK;
                        r_mem_wdata <= w_wdata;
                        r_mem_wmask <= w_wmask;
                        r_wdog      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr       <= rr_next_ptr(w_win_id);
`endif
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (r_win != REQ_ST) r_resp <= bus.mem_rdata;
                        r_if_done <= (r_win == REQ_IF);
                        r_ld_done <= (r_win == REQ_LD);
                        r_st_done <= (r_win == REQ_ST);
                        r_state   <= ST_DONE;
                    end else if (TIMEOUT != 0 && r_wdog == WD_LAST) begin
                        // Abort still completes the requester so it can retry.
                        r_mem_req <= 1'b0;
                        r_resp    <= '0;
                        r_tmo     <= 1'b1;
                        r_if_done <= (r_win == REQ_IF);
                        r_ld_done <= (r_win == REQ_LD);
                        r_st_done <= (r_win == REQ_ST);
                        r_state   <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_if_done <= 1'b0;
                    r_ld_done <= 1'b0;
                    r_st_done <= 1'b0;
                    r_tmo     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_done     = r_if_done;
    assign bus.ld_done     = r_ld_done;
    assign bus.st_done     = r_st_done;
    assign bus.resp_data   = r_resp;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wmask   = r_mem_wmask;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_tmo;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a transaction-level model predicts
// each grant and completion; a negedge monitor pops and compares.
module tb_dcache_port_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } grant_t;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] data;
        logic        tmo;
    } done_t;

    grant_t exp_grant[$];
    done_t  exp_done[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rst_edge = 1'b0;

    // model / memory plan
    int          free_at = 0;
    int          busy_hi = -1;
    int          ready_edge = -1;
    logic [31:0] ready_data = '0;
    int          lat_override = 0;
    bit          rdata_ov_en = 1'b0;
    logic [31:0] rdata_override = '0;
`ifdef ARB_ROUND_ROBIN_EN
    int          last_win = -1;
`endif

    // requester stimulus modes: 0 idle, 1 random, 2 re-request continuously
    int auto_mode[3] = '{0, 0, 0};
    bit mask_fixed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    task automatic model_grant();
        int    seq[3] = '{2, 1, 0};   // priority order ST, LD, IF
        bit    pend[3];
        int    start, win, lat, c;
        logic [31:0] data;
        grant_t g;
        done_t  d;
        pend[0] = bus.if_req;
        pend[1] = bus.ld_req;
        pend[2] = bus.st_req;
        start = 0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++)
            if (last_win >= 0 && seq[k] == last_win) start = (k + 1) % 3;
`endif
        win = -1;
        for (int k = 0; k < 3; k++)
            if (win < 0 && pend[seq[(start + k) % 3]]) win = seq[(start + k) % 3];
`ifdef ARB_ROUND_ROBIN_EN
        last_win = win;
`endif
        if (lat_override != 0) lat = lat_override;
        else if ($urandom_range(0, 9) == 0) lat = TO + 2;
        else lat = int'($urandom_range(1, 3));
        data = rdata_ov_en ? rdata_override : $urandom();

        g.cyc   = cyc;
        g.addr  = (win == 2) ? bus.st_addr : (win == 1) ? bus.ld_addr : bus.if_addr;
        g.addr  = g.addr & 32'hFFFF_FFFC;
        g.we    = (win == 2);
        g.wdata = (win == 2) ? bus.st_wdata : 32'h0;
        g.wmask = (win == 2) ? bus.st_wmask : 4'hF;
        c       = (lat <= TO) ? cyc + lat : cyc + TO;
        d.cyc   = c;
        d.id    = win;
        d.tmo   = (lat > TO);
        d.data  = (lat <= TO) ? data : 32'h0;
        exp_grant.push_back(g);
        exp_done.push_back(d);
        ready_edge = (lat <= TO) ? cyc + lat : -1;
        ready_data = data;
        busy_hi    = c;
        free_at    = c + 2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = !rst;
            if (!rst) begin
                while (exp_done.size() > 0 && exp_done[$].cyc >= cyc) void'(exp_done.pop_back());
                while (exp_grant.size() > 0 && exp_grant[$].cyc >= cyc) void'(exp_grant.pop_back());
                free_at = 0;
                busy_hi = -1;
`ifdef ARB_ROUND_ROBIN_EN
                last_win = -1;
`endif
            end else if (cyc >= free_at && (bus.if_req || bus.ld_req || bus.st_req)) begin
                model_grant();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit     prev_req = 1'b0;
        int     last_done = -10;
        grant_t g;
        done_t  d;
        logic [2:0] dn;
        forever begin
            @(negedge clk);
            dn = {bus.st_done, bus.ld_done, bus.if_done};
            if (rst_edge) begin
                chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
                chk("rst_busy", 32'(bus.busy), 32'h0);
                chk("rst_done", 32'(dn), 32'h0);
                chk("rst_tmo", 32'(bus.timeout_err), 32'h0);
                prev_req = 1'b0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    if (exp_grant.size() == 0) begin
                        chk("unexpected_grant", 32'(bus.mem_req), 32'h0);
                    end else begin
                        g = exp_grant.pop_front();
                        chk("grant_cyc", 32'(cyc), 32'(g.cyc));
                        chk("mem_addr", bus.mem_addr, g.addr);
                        chk("mem_we", 32'(bus.mem_we), 32'(g.we));
                        chk("mem_wmask", 32'(bus.mem_wmask), 32'(g.wmask));
                        if (g.we) chk("mem_wdata", bus.mem_wdata, g.wdata);
                        chk("grant_busy", 32'(bus.busy), 32'h1);
                        $display("grant  cyc=%0d addr=%h we=%0d wmask=%h", cyc, bus.mem_addr, bus.mem_we, bus.mem_wmask);
                    end
                end
                prev_req = bus.mem_req;
                if (dn != 3'b000 || bus.timeout_err) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 32'(dn), 32'h0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_cyc", 32'(cyc), 32'(d.cyc));
                        chk("done_onehot", 32'(dn), 32'(3'b001 << d.id));
                        chk("timeout_err", 32'(bus.timeout_err), 32'(d.tmo));
                        if (d.id != 2 || d.tmo) chk("resp_data", bus.resp_data, d.data);
                        chk("done_mem_req", 32'(bus.mem_req), 32'h0);
                        last_done = cyc;
                        $display("done   cyc=%0d id=%0d resp=%h tmo=%0d", cyc, d.id, bus.resp_data, bus.timeout_err);
                    end
                end
                if (cyc == last_done + 1) chk("idle_busy", 32'(bus.busy), 32'h0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic raise_req(input int r);
        case (r)
            0: begin bus.if_req = 1'b1; bus.if_addr = $urandom(); end
            1: begin bus.ld_req = 1'b1; bus.ld_addr = $urandom(); end
            default: begin
                bus.st_req   = 1'b1;
                bus.st_addr  = $urandom();
                bus.st_wdata = $urandom();
                bus.st_wmask = mask_fixed ? 4'b0011 : 4'($urandom());
            end
        endcase
    endtask

    task automatic drive_cycle();
        bit dropped[3] = '{0, 0, 0};
        bit cur[3];
        if (bus.if_done && bus.if_req) begin bus.if_req = 1'b0; dropped[0] = 1'b1; end
        if (bus.ld_done && bus.ld_req) begin bus.ld_req = 1'b0; dropped[1] = 1'b1; end
        if (bus.st_done && bus.st_req) begin bus.st_req = 1'b0; dropped[2] = 1'b1; end
        cur[0] = bus.if_req;
        cur[1] = bus.ld_req;
        cur[2] = bus.st_req;
        for (int r = 0; r < 3; r++) begin
            if (!cur[r] && !dropped[r]) begin
                if (auto_mode[r] == 2) raise_req(r);
                else if (auto_mode[r] == 1 && $urandom_range(0, 99) < 30) raise_req(r);
            end
        end
        if (cyc + 1 == ready_edge) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = ready_data;
        end else if (cyc + 1 > busy_hi && $urandom_range(0, 3) == 0) begin
            bus.mem_ready = 1'b1;    // outside BUSY: must be ignored
            bus.mem_rdata = $urandom();
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom();
        end
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive_cycle();
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while ((bus.if_req || bus.ld_req || bus.st_req || exp_done.size() != 0
                || exp_grant.size() != 0) && k < max_cyc) begin
            @(negedge clk);
            drive_cycle();
            k++;
        end
        if (k >= max_cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected completions outstanding after %0d cycles", exp_done.size(), k);
        end
        run_cycles(3);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ld_req = 1'b0; bus.ld_addr = '0;
        bus.st_req = 1'b0; bus.st_addr = '0; bus.st_wdata = '0; bus.st_wmask = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;

        // reset held 3 cycles with a load pending, then single load
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'h1006;
        lat_override = 1;
        rdata_ov_en = 1'b1;
        rdata_override = 32'hDEADBEEF;
        run_cycles(3);
        rst = 1'b1;
        wait_idle(50);
        rdata_ov_en = 1'b0;

        // three-way contention, two BUSY cycles each
        lat_override = 2;
        mask_fixed = 1'b1;
        @(negedge clk);
        raise_req(0);
        raise_req(1);
        raise_req(2);
        wait_idle(100);
        mask_fixed = 1'b0;

        // ST and IF re-requesting back to back
        lat_override = 1;
        auto_mode[0] = 2;
        auto_mode[2] = 2;
        run_cycles(40);
        auto_mode[0] = 0;
        auto_mode[2] = 0;
        wait_idle(100);

        // watchdog abort
        lat_override = TO + 3;
        @(negedge clk);
        raise_req(1);
        wait_idle(50);

        // reset in the second BUSY cycle; the planned mem_ready lands afterwards
        lat_override = 3;
        @(negedge clk);
        raise_req(1);
        for (int k = 0; k < 20 && !bus.mem_req; k++) run_cycles(1);
        run_cycles(1);
        rst = 1'b0;
        bus.ld_req = 1'b0;
        run_cycles(1);
        rst = 1'b1;
        run_cycles(12);
        wait_idle(50);

        // randomized traffic on all three requesters
        lat_override = 0;
        auto_mode = '{1, 1, 1};
        run_cycles(1500);
        auto_mode = '{0, 0, 0};
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_vec++;
        n_err++;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-memory port between three requesters:
  - instruction-fetch refill (IF),
  - load-store-unit load read (LD),
  - ROB store commit (ST).
- One memory transaction in flight at a time.
- Sits between the LoadStore/ROB/fetch logic and the memory/cache bus.
- Sequences each access as grant -> hold -> completion pulse.

Parameters:
- ADDR_W, 32, address width (matches Addr_Width).
- DATA_W, 32, data width (matches Data_Width).
- TIMEOUT, 64, cycles waited for mem_ready before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- if_req  in  1  IF read request, held until if_done
- if_addr  in  ADDR_W  IF byte address
- if_done  out  1  one-cycle completion pulse to IF
- ld_req  in  1  LD read request, held until ld_done
- ld_addr  in  ADDR_W  LD byte address
- ld_done  out  1  one-cycle completion pulse to LD
- st_req  in  1  ST write request, held until st_done
- st_addr  in  ADDR_W  ST byte address
- st_wdata  in  DATA_W  store data, already lane-aligned
- st_wmask  in  4  byte enables
- st_done  out  1  one-cycle completion pulse to ST
- resp_data  out  DATA_W  read data, valid while if_done or ld_done is high
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (addr & ~3)
- mem_wdata  out  DATA_W  write data
- mem_wmask  out  4  byte enables (4'hF for reads)
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- All outputs are registered.
- Reset (rst==0 at posedge) → state IDLE. All of the following clear to 0: done pulses, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, resp_data, busy, timeout_err, watchdog counter, RR pointer.
- Reset mid-transaction drops mem_req on that edge. No done pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req is high, select a winner: fixed priority ST > LD > IF.
  - Latch winner id, address, data and mask into the mem_* registers. Set mem_req=1 and mem_we=(winner==ST). Go to BUSY.
  - If no req is high, stay in IDLE.
- BUSY:
  - mem_* are held stable.
  - On mem_ready:
    - mem_req goes to 0.
    - For reads, resp_data is loaded from mem_rdata.
    - The winner's done is set to 1.
    - Go to DONE.
  - The watchdog counts BUSY cycles. When TIMEOUT!=0 and count==TIMEOUT-1 without mem_ready:
    - mem_req goes to 0, timeout_err pulses, the winner's done pulses, resp_data is set to 0.
    - Go to DONE.
- DONE:
  - done is high for exactly this cycle; it clears on exit.
  - Go to IDLE. No arbitration happens in DONE.
  - The requester must drop req at the edge after it samples done.
- Minimum latency: req sampled at edge 0 → mem_req high in cycle 1 → mem_ready in cycle 1 → done in cycle 2 → next grant possible at edge 3.
- Requests arriving while BUSY/DONE wait. They are never lost while held.
- Simultaneous requests: only one is granted per IDLE pass.
- mem_ready outside BUSY is ignored.
- Request inputs that change while BUSY do not alter the latched transaction.
- mem_addr[1:0] is always 0. st_wmask is passed through unmodified; the arbiter does no alignment checks.

Optional Feature:
- ARB_ROUND_ROBIN_EN
  - Defined: rotating priority. After a grant to requester k, the order starts at k+1 (order ST, LD, IF, wrap). Prevents IF starvation under load/store bursts.
  - Undefined: fixed ST > LD > IF; no pointer register.

Decomposition:
- Shared package/defines: requester ids (REQ_IF=2'd0, REQ_LD=2'd1, REQ_ST=2'd2), FSM state encodings, reuse Addr_Width/Data_Width/Addr_Mask.
- One natural sub-module, arb_pick3: combinational 3-way picker with an optional rotate pointer. Returns the grant one-hot.

Test Plan:
- Reset: hold rst=0 for 3 cycles while ld_req=1 → mem_req=0, busy=0, all done=0. Release → mem_req=1 next cycle, mem_addr=ld_addr&~3.
- Single load: ld_addr=32'h1006, mem_ready in the first BUSY cycle with mem_rdata=32'hDEADBEEF → mem_addr=32'h1004, mem_we=0; ld_done pulses 1 cycle with resp_data=32'hDEADBEEF, 2 cycles after the request was sampled.
- Contention, fixed priority: if/ld/st all high in the same cycle, mem_ready after 2 BUSY cycles each → grant order ST, LD, IF. Store shows mem_we=1, mem_wmask=st_wmask=4'b0011, mem_wdata=st_wdata.
- Round robin (ARB_ROUND_ROBIN_EN): ST and IF continuously re-request → grants alternate ST, IF, ST, IF.
- Watchdog: TIMEOUT=4, mem_ready never asserted → after 4 BUSY cycles, timeout_err and ld_done pulse together, resp_data=0, FSM returns to IDLE.
- Reset mid-BUSY: assert rst=0 in the 2nd BUSY cycle → mem_req=0 the next cycle, no done pulse; a later mem_ready is ignored.
